// File: rtl/regbus_matrix_pkg.sv
// Shared op codes and helpers for the register-file / internal-bus interconnect.
package regbus_matrix_pkg;

  localparam int REGBUS_OP_W = 3;

  typedef enum logic [REGBUS_OP_W-1:0] {
    REGBUS_IDLE  = 3'd0,
    REGBUS_LOAD  = 3'd1,
    REGBUS_DRIVE = 3'd2,
    REGBUS_INC   = 3'd3,
    REGBUS_DEC   = 3'd4
  } regbus_op_e;

  // A single bus still needs a one-bit select field.
  function automatic int bsel_width(input int num_buses);
    return (num_buses > 1) ? $clog2(num_buses) : 1;
  endfunction

endpackage

// File: rtl/regbus_bus_mux.sv
// One internal bus: priority select (external source, then lowest-index DRIVE register)
// and multi-driver detection. Purely combinational.
module regbus_bus_mux
  import regbus_matrix_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int BSEL_W   = 1,
  parameter int BUS_IDX  = 0
) (
  input  logic                          ext_drive,
  input  logic [DATA_W-1:0]             ext_data,
  input  logic [NUM_REGS*REGBUS_OP_W-1:0] reg_op,
  input  logic [NUM_REGS*BSEL_W-1:0]    reg_bsel,
  input  logic [NUM_REGS*DATA_W-1:0]    reg_q,
  output logic [DATA_W-1:0]             bus_val,
  output logic                          multi_drive
);

  localparam logic [BSEL_W-1:0] IDX = BSEL_W'(BUS_IDX);

  logic              seen;
  logic              found;
  logic [DATA_W-1:0] reg_val;

  always_comb begin
    seen        = ext_drive;
    found       = 1'b0;
    multi_drive = 1'b0;
    reg_val     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_op[i*REGBUS_OP_W +: REGBUS_OP_W] == REGBUS_DRIVE &&
          reg_bsel[i*BSEL_W +: BSEL_W] == IDX) begin
        // A second driver of any kind makes this a conflict.
        multi_drive = multi_drive | seen;
        seen        = 1'b1;
        if (!found) reg_val = reg_q[i*DATA_W +: DATA_W];
        found = 1'b1;
      end
    end
    bus_val = ext_drive ? ext_data : reg_val;
  end

endmodule

// File: rtl/regbus_matrix.sv
// Register file on NUM_BUSES internal buses: LOAD/INC/DEC land one cycle later,
// rdy=0 freezes registers (buses and contention flags keep working).
module regbus_matrix
  import regbus_matrix_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter int                NUM_BUSES = 2,
  parameter int                SP_INDEX  = 3,
  parameter logic [DATA_W-1:0] SP_RESET  = 8'hFF,
  parameter int                BSEL_W    = bsel_width(NUM_BUSES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rdy,
  input  logic [NUM_REGS*REGBUS_OP_W-1:0] reg_op,
  input  logic [NUM_REGS*BSEL_W-1:0]      reg_bsel,
  input  logic [NUM_BUSES-1:0]            ext_drive,
  input  logic [NUM_BUSES*DATA_W-1:0]     ext_data,
  input  logic                            clr_err,
  output logic [NUM_BUSES*DATA_W-1:0]     bus_out,
  output logic [NUM_REGS*DATA_W-1:0]      reg_q,
  output logic [NUM_REGS-1:0]             reg_updated,
  output logic [NUM_BUSES-1:0]            contention
);

  // One extra bit so selects past the last bus compare correctly.
  localparam logic [BSEL_W:0] BUS_LIM = (BSEL_W+1)'(NUM_BUSES);

  logic [DATA_W-1:0]    bus_val [NUM_BUSES];
  logic [NUM_BUSES-1:0] multi;

  for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
    regbus_bus_mux #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .BSEL_W  (BSEL_W),
      .BUS_IDX (b)
    ) u_mux (
      .ext_drive  (ext_drive[b]),
      .ext_data   (ext_data[b*DATA_W +: DATA_W]),
      .reg_op     (reg_op),
      .reg_bsel   (reg_bsel),
      .reg_q      (reg_q),
      .bus_val    (bus_val[b]),
      .multi_drive(multi[b])
    );
    assign bus_out[b*DATA_W +: DATA_W] = bus_val[b];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (i == SP_INDEX) ? SP_RESET : '0;

    logic [REGBUS_OP_W-1:0] op;
    logic [BSEL_W-1:0]      bsel;
    logic [DATA_W-1:0]      q;
    logic [DATA_W-1:0]      nxt;

    assign op   = reg_op[i*REGBUS_OP_W +: REGBUS_OP_W];
    assign bsel = reg_bsel[i*BSEL_W +: BSEL_W];

    always_comb begin
      nxt = q;
      case (op)
        REGBUS_LOAD: if ({1'b0, bsel} < BUS_LIM) nxt = bus_val[bsel];
        REGBUS_INC:  nxt = q + DATA_W'(1);
        REGBUS_DEC:  nxt = q - DATA_W'(1);
        default:     nxt = q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q              <= RST_VAL;
        reg_updated[i] <= 1'b0;
      end else if (rdy) begin
        q              <= nxt;
        reg_updated[i] <= (nxt != q);
      end else begin
        reg_updated[i] <= 1'b0;
      end
    end

    assign reg_q[i*DATA_W +: DATA_W] = q;
  end

  // New conflicts take priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) contention <= '0;
    else        contention <= (contention & ~{NUM_BUSES{clr_err}}) | multi;
  end

endmodule

// File: tb/tb_regbus_matrix.sv
// Scoreboarded bench: directed scenarios then random traffic against an array-based model.
module tb_regbus_matrix;
  import regbus_matrix_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NB = 2;
  localparam int BW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic [NR*3-1:0]   reg_op;
  logic [NR*BW-1:0]  reg_bsel;
  logic [NB-1:0]     ext_drive;
  logic [NB*DW-1:0]  ext_data;
  logic              clr_err;
  logic [NB*DW-1:0]  bus_out;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     reg_updated;
  logic [NB-1:0]     contention;

  regbus_matrix #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_BUSES(NB), .SP_INDEX(3), .SP_RESET(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .reg_op(reg_op), .reg_bsel(reg_bsel),
    .ext_drive(ext_drive), .ext_data(ext_data), .clr_err(clr_err),
    .bus_out(bus_out), .reg_q(reg_q), .reg_updated(reg_updated), .contention(contention)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] q;
    logic [NR-1:0]    upd;
    logic [NB-1:0]    cont;
  } st_t;

  logic [NB*DW-1:0] bus_q [$];
  st_t              st_q  [$];

  int m_reg [NR];
  bit m_cont [NB];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [11:0] ops(input int a, input int x, input int y, input int s);
    return {3'(s), 3'(y), 3'(x), 3'(a)};
  endfunction

  // Apply one cycle of inputs and predict bus values and the post-edge state.
  task automatic step(input bit r, input bit rd, input logic [11:0] op, input logic [3:0] bs,
                      input logic [1:0] ed, input logic [15:0] edat, input bit clr);
    int   bus [NB];
    int   drv [NB];
    int   o, nv;
    st_t  e;
    logic [NB*DW-1:0] be;
    @(negedge clk);
    rst_n = r; rdy = rd; reg_op = op; reg_bsel = bs;
    ext_drive = ed; ext_data = edat; clr_err = clr;
    for (int b = 0; b < NB; b++) begin
      drv[b] = int'(ed[b]);
      bus[b] = ed[b] ? int'(edat[b*DW +: DW]) : -1;
      for (int i = 0; i < NR; i++) begin
        o = int'(op[i*3 +: 3]);
        if (o == 2 && int'(bs[i]) == b) begin
          drv[b]++;
          if (bus[b] < 0) bus[b] = m_reg[i];
        end
      end
      if (bus[b] < 0) bus[b] = 0;
      be[b*DW +: DW] = DW'(bus[b]);
    end
    bus_q.push_back(be);
    e.upd = '0;
    if (!r) begin
      for (int i = 0; i < NR; i++) m_reg[i] = (i == 3) ? 255 : 0;
      for (int b = 0; b < NB; b++) m_cont[b] = 0;
    end else begin
      for (int b = 0; b < NB; b++)
        if (drv[b] >= 2) m_cont[b] = 1;
        else if (clr) m_cont[b] = 0;
      if (rd) begin
        for (int i = 0; i < NR; i++) begin
          o  = int'(op[i*3 +: 3]);
          nv = m_reg[i];
          if (o == 1 && int'(bs[i]) < NB) nv = bus[int'(bs[i])];
          else if (o == 3) nv = (nv + 1) % 256;
          else if (o == 4) nv = (nv + 255) % 256;
          e.upd[i] = (nv != m_reg[i]);
          m_reg[i] = nv;
        end
      end
    end
    for (int i = 0; i < NR; i++) e.q[i*DW +: DW] = DW'(m_reg[i]);
    for (int b = 0; b < NB; b++) e.cont[b] = m_cont[b];
    st_q.push_back(e);
  endtask

  // Bus values are combinational: sample mid-cycle, after inputs settle.
  initial begin : bus_mon
    logic [NB*DW-1:0] be;
    forever begin
      @(negedge clk);
      #2;
      if (bus_q.size() > 0) begin
        be = bus_q.pop_front();
        chk("bus_out", 64'(bus_out), 64'(be));
      end
    end
  end

  initial begin : st_mon
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("reg_q", 64'(reg_q), 64'(e.q));
        chk("reg_updated", 64'(reg_updated), 64'(e.upd));
        chk("contention", 64'(contention), 64'(e.cont));
      end
    end
  end

  localparam int I = 0, L = 1, D = 2, N = 3, M = 4;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; reg_op = '0; reg_bsel = '0;
    ext_drive = '0; ext_data = '0; clr_err = 1'b0;
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    for (int b = 0; b < NB; b++) m_cont[b] = 0;

    step(0, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);
    step(0, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);
    // Transfer through bus 1 then bus 0.
    step(1, 1, ops(L, I, I, I), 4'b0001, 2'b10, 16'h5A00, 0);
    step(1, 1, ops(D, L, I, I), 4'b0000, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);
    // Stack pointer wrap both ways.
    step(1, 1, ops(I, I, I, N), 4'h0, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, M), 4'h0, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, M), 4'h0, 2'b00, 16'h0000, 0);
    // Contention: set, hold, clear, clear-vs-set.
    step(1, 1, ops(L, I, L, I), 4'b0100, 2'b11, 16'h2211, 0);
    step(1, 1, ops(D, I, D, I), 4'b0000, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 1);
    step(1, 1, ops(D, I, D, I), 4'b0000, 2'b00, 16'h0000, 1);
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 1);
    // Stall then release with identical ops.
    step(1, 0, ops(L, N, I, I), 4'b0000, 2'b01, 16'h0033, 0);
    step(1, 1, ops(L, N, I, I), 4'b0000, 2'b01, 16'h0033, 0);
    // Identical-value load gives no update pulse.
    step(1, 1, ops(L, I, I, I), 4'b0000, 2'b01, 16'h0033, 0);
    // Reset beats a pending op, next op is honoured.
    step(0, 1, ops(I, I, I, M), 4'h0, 2'b00, 16'h0000, 0);
    step(1, 1, ops(I, I, I, M), 4'h0, 2'b00, 16'h0000, 0);
    step(0, 0, ops(N, N, N, N), 4'h0, 2'b11, 16'hABCD, 0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
           12'($urandom), 4'($urandom), 2'($urandom), 16'($urandom),
           ($urandom_range(0, 9) == 0));
    end
    step(1, 1, ops(I, I, I, I), 4'h0, 2'b00, 16'h0000, 0);

    for (int k = 0; k < 20 && (bus_q.size() > 0 || st_q.size() > 0); k++) @(posedge clk);
    #3;
    if (bus_q.size() > 0 || st_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d bus and %0d state expectations left, required 0",
               bus_q.size(), st_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
